// File: rtl/audio_pkg.sv
// Shared constants, sample types and FSM encoding for the PSG audio decimator.
// Latency/backpressure: none here; types only.
package audio_pkg;

  localparam int BLOCK_LEN = 64;
  localparam int DCB_SHIFT = 8;
  localparam int CNT_W     = $clog2(BLOCK_LEN);

  typedef logic [7:0]         psg_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [13:0]        acc_t;
  typedef logic signed [15:0] pcm_t;
  typedef logic signed [17:0] dcb_t;

  typedef struct packed {
    acc_t l;
    acc_t r;
  } acc_pair_t;

  typedef enum logic [1:0] {
    IDLE,
    FILT_L,
    FILT_R,
    OUT
  } state_t;

  // Block sum (0..16320) scaled by 4 and re-centred on zero: -32768..+32512.
  function automatic pcm_t to_pcm(acc_t s);
    return pcm_t'({s, 2'b00} - 16'h8000);
  endfunction

endpackage

// File: rtl/audio_dcblock.sv
// One-channel DC blocker y = x - x_prev + y_prev - (y_prev >>> DCB_SHIFT), saturated to 16 bits.
// Purely combinational; shared between channels by the caller, no backpressure.
module audio_dcblock
  import audio_pkg::*;
(
  input  logic signed [15:0] x,
  input  logic signed [15:0] x_prev,
  input  logic signed [15:0] y_prev,
  output logic signed [15:0] y
);

  dcb_t sum;

  always_comb begin
    sum = dcb_t'(x) - dcb_t'(x_prev) + dcb_t'(y_prev) - (dcb_t'(y_prev) >>> DCB_SHIFT);
    if (sum > 18'sd32767) begin
      y = 16'sh7fff;
    end else if (sum < -18'sd32768) begin
      y = 16'sh8000;
    end else begin
      y = sum[15:0];
    end
  end

endmodule

// File: rtl/audio_decim.sv
// Sums 64 PSG strobes per channel into one signed 16-bit stereo sample; optional DC blocker under AUDIO_DCBLOCK_EN.
// out_valid 3 clk after the 64th strobe; no backpressure: a block ending while the FSM is busy is dropped and sets sticky overrun.
module audio_decim
  import audio_pkg::*;
(
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ce_sample,
  input  logic [7:0]         audio_l,
  input  logic [7:0]         audio_r,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic               out_valid,
  output logic               overrun
);

  cnt_t      cnt;
  acc_pair_t acc;
  acc_pair_t snap;
  acc_pair_t sum;
  state_t    state;
  state_t    state_nxt;
  logic      start;
  pcm_t      x;
  pcm_t      x_prev;
  pcm_t      y_prev;
  pcm_t      y;
  pcm_t      res_l;
  pcm_t      res_r;

  always_comb begin
    sum.l = acc.l + acc_t'(audio_l);
    sum.r = acc.r + acc_t'(audio_r);
  end

  assign start = ce_sample && (cnt == cnt_t'(BLOCK_LEN - 1));

  // Accumulation never stalls; only the snapshot is skipped when the FSM is busy.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      snap    <= '0;
      overrun <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      acc <= '0;
      if (state == IDLE) begin
        snap <= sum;
      end else begin
        overrun <= 1'b1;
      end
    end else if (ce_sample) begin
      cnt <= cnt + cnt_t'(1);
      acc <= sum;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILT_L;
      FILT_L:  state_nxt = FILT_R;
      FILT_R:  state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign x = to_pcm((state == FILT_R) ? snap.r : snap.l);

`ifdef AUDIO_DCBLOCK_EN
  pcm_t xh_l;
  pcm_t xh_r;
  pcm_t yh_l;
  pcm_t yh_r;

  assign x_prev = (state == FILT_R) ? xh_r : xh_l;
  assign y_prev = (state == FILT_R) ? yh_r : yh_l;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      xh_l <= '0;
      xh_r <= '0;
      yh_l <= '0;
      yh_r <= '0;
    end else if (state == FILT_L) begin
      xh_l <= x;
      yh_l <= y;
    end else if (state == FILT_R) begin
      xh_r <= x;
      yh_r <= y;
    end
  end
`else
  // Zero history makes the shared datapath a pass-through: y == x.
  assign x_prev = '0;
  assign y_prev = '0;
`endif

  audio_dcblock u_dcblock (
    .x      (x),
    .x_prev (x_prev),
    .y_prev (y_prev),
    .y      (y)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      res_l     <= '0;
      res_r     <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == OUT);
      if (state == FILT_L) res_l <= y;
      if (state == FILT_R) res_r <= y;
      if (state == OUT) begin
        out_l <= res_l;
        out_r <= res_r;
      end
    end
  end

endmodule

// File: tb/tb_audio_decim.sv
// Randomised bench for audio_decim: behavioural block-sum model with a per-cycle output compare plus literal spot checks.
module tb_audio_decim;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ce_sample = 1'b0;
  logic [7:0]         audio_l = 8'h00;
  logic [7:0]         audio_r = 8'h00;
  logic signed [15:0] out_l;
  logic signed [15:0] out_r;
  logic               out_valid;
  logic               overrun;

  audio_decim dut (
    .clk_sys   (clk),
    .reset     (reset),
    .ce_sample (ce_sample),
    .audio_l   (audio_l),
    .audio_r   (audio_r),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain running sums per channel, one expected sample per 64 strobes.
  typedef struct {
    int due;
    int l;
    int r;
  } exp_t;

  exp_t exp_q[$];
  int   sum_l, sum_r, n_strobe, last_take;
  int   xp_l, yp_l, xp_r, yp_r;
  bit   model_en = 1'b1;
  int   pulses;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic dcb_step(input int xv, inout int xp, inout int yp, output int yv);
`ifdef AUDIO_DCBLOCK_EN
    yv = sat16(xv - xp + yp - (yp >>> 8));
    xp = xv;
    yp = yv;
`else
    yv = xv;
`endif
  endtask

  task automatic model_take(input int l, input int r);
    int yl, yr;
    sum_l += l;
    sum_r += r;
    n_strobe++;
    last_take = cyc + 1;
    if (n_strobe == 64) begin
      dcb_step(sum_l * 4 - 32768, xp_l, yp_l, yl);
      dcb_step(sum_r * 4 - 32768, xp_r, yp_r, yr);
      exp_q.push_back('{due: cyc + 4, l: yl, r: yr});
      sum_l = 0;
      sum_r = 0;
      n_strobe = 0;
    end
  endtask

  task automatic model_flush();
    while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    sum_l = 0; sum_r = 0; n_strobe = 0;
    xp_l = 0; yp_l = 0; xp_r = 0; yp_r = 0;
  endtask

  always @(negedge clk) begin
    if (model_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("model_valid", int'(out_valid), 1);
        chk("model_out_l", int'(out_l), exp_q[0].l);
        chk("model_out_r", int'(out_r), exp_q[0].r);
        void'(exp_q.pop_front());
      end else begin
        chk("model_no_valid", int'(out_valid), 0);
      end
      chk("model_overrun", int'(overrun), 0);
    end
  end

  task automatic drive(input bit ce, input int l, input int r);
    @(posedge clk);
    #1;
    ce_sample = ce;
    audio_l   = 8'(l);
    audio_r   = 8'(r);
    if (ce) model_take(l, r);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    ce_sample = 1'b0;
    model_flush();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_l", int'(out_l), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
  endtask

  task automatic wait_out(input string name, input int el, input int er);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    chk({name, "_seen"}, int'(got), 1);
    if (got) begin
      chk({name, "_latency"}, cyc - last_take, 3);
      chk({name, "_l"}, int'(out_l), el);
      chk({name, "_r"}, int'(out_r), er);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    do_reset();

    // Mid-scale input gives zero output.
    repeat (64) drive(1'b1, 8'h80, 8'h80);
    drive(1'b0, 0, 0);
    wait_out("blk_mid", 0, 0);

    // Full-scale extremes.
    do_reset();
    repeat (64) drive(1'b1, 8'hFF, 8'h00);
    drive(1'b0, 0, 0);
    wait_out("blk_ext", 32512, -32768);
`ifdef AUDIO_DCBLOCK_EN
    repeat (64) drive(1'b1, 8'hFF, 8'h00);
    drive(1'b0, 0, 0);
    wait_out("dcb_decay", 32385, -32640);
`endif

    // Reset partway through a block leaves no residue.
    do_reset();
    repeat (40) drive(1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
    do_reset();
    repeat (64) drive(1'b1, 8'hFF, 8'hFF);
    drive(1'b0, 0, 0);
    wait_out("post_reset", 32512, 32512);

    // Back-to-back blocks: strobes land while the FSM is in OUT.
    do_reset();
    repeat (64) drive(1'b1, 8'h80, 8'h80);
    repeat (64) drive(1'b1, 8'hFF, 8'hFF);
    drive(1'b0, 0, 0);
    wait_out("ce_in_out", 32512, 32512);

    // Random samples and strobe density, checked by the model every cycle.
    do_reset();
    for (int i = 0; i < 700; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255));
    end
    while (n_strobe != 63) drive(1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
    drive(1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
    end
    repeat (8) drive(1'b0, 0, 0);

    // Two starts one idle cycle apart: second is dropped and flags overrun.
    model_en = 1'b0;
    @(posedge clk); #1; force dut.start = 1'b1;
    @(posedge clk); #1; force dut.start = 1'b0;
    @(posedge clk); #1; force dut.start = 1'b1;
    @(posedge clk); #1; release dut.start;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("overrun_pulses", pulses, 1);
    chk("overrun_set", int'(overrun), 1);
    repeat (20) @(negedge clk);
    chk("overrun_held", int'(overrun), 1);
    do_reset();
    model_en = 1'b1;
    repeat (64) drive(1'b1, 8'hFF, 8'h00);
    drive(1'b0, 0, 0);
    wait_out("after_overrun", 32512, -32768);
    repeat (4) drive(1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_decim.md
AUDIO_DECIM -- requirements
Module: audio_decim

Interface
REQ-001 SHALL have port clk_sys, input, 1 bit: system clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port ce_sample, input, 1 bit: one-clock input-sample strobe, connected to ce_4p.
REQ-004 SHALL have port audio_l, input, 8 bits: left PSG sample, unsigned; sampled only when ce_sample=1.
REQ-005 SHALL have port audio_r, input, 8 bits: right PSG sample, unsigned; sampled only when ce_sample=1.
REQ-006 SHALL have port out_l, output, 16 bits: left output sample, signed two's complement; drives AUDIO_L.
REQ-007 SHALL have port out_r, output, 16 bits: right output sample, signed two's complement; drives AUDIO_R.
REQ-008 SHALL have port out_valid, output, 1 bit: one-clock pulse when out_l/out_r are updated.
REQ-009 SHALL have port overrun, output, 1 bit: sticky flag, block completed while filter busy.

Function
REQ-010 SHALL keep a 6-bit strobe counter cnt and two 14-bit accumulators acc_l and acc_r.
REQ-011 On ce_sample when cnt<63, SHALL add each channel sample to its accumulator and increment cnt.
REQ-012 On ce_sample when cnt=63, SHALL latch snap_l=acc_l+audio_l and snap_r=acc_r+audio_r, clear both accumulators, wrap cnt to 0 and raise start.
REQ-013 SHALL form x = {snap,2'b00} - 32768 as a 16-bit signed value; range -32768..+32512, never overflows.
REQ-014 FSM states: IDLE, FILT_L, FILT_R, OUT.
REQ-015 FSM transitions: IDLE->FILT_L on start, FILT_L->FILT_R, FILT_R->OUT, OUT->IDLE, one clock each.
REQ-016 FILT_L SHALL process the left channel, FILT_R the right channel, through one shared datapath.
REQ-017 In OUT, SHALL register out_l/out_r and assert out_valid for exactly one clock.
REQ-018 out_valid SHALL assert exactly 3 clocks after the clock on which the 64th strobe is taken.
REQ-019 If start occurs while FSM is not IDLE, SHALL discard the new snapshot, keep the FSM path running and set overrun; overrun is cleared only by reset.
REQ-020 Accumulation SHALL continue unaffected while the FSM is busy.
REQ-021 ce_sample on the same clock as OUT SHALL be accumulated normally.

Reset
REQ-022 On reset, SHALL clear cnt, acc_l, acc_r, snap_l and snap_r.
REQ-023 On reset, SHALL set FSM=IDLE and clear the DC history.
REQ-024 On reset, SHALL drive out_l=0, out_r=0, out_valid=0 and overrun=0.
REQ-025 Reset asserted mid-block or mid-FSM SHALL abort with no out_valid pulse; the first post-reset block completes after 64 strobes.

Configuration
REQ-026 With macro AUDIO_DCBLOCK_EN defined, each channel SHALL compute y = x - x_prev + y_prev - (y_prev >>> 8).
REQ-027 The REQ-026 computation SHALL be 18-bit signed and saturate y to -32768..+32767.
REQ-028 With AUDIO_DCBLOCK_EN defined, SHALL store x_prev=x and y_prev=saturated y per channel, and output y.
REQ-029 Without AUDIO_DCBLOCK_EN, SHALL output x directly, omit the history registers, and keep FSM timing unchanged.

Structure
REQ-030 Package audio_pkg SHALL hold BLOCK_LEN=64, DCB_SHIFT=8, the FSM state enum and the sample typedefs.
REQ-031 Sub-module audio_dcblock SHALL be the single-channel, combinational-plus-saturate datapath, instantiated once and time-multiplexed by the FSM.
REQ-032 Per-channel history SHALL live in audio_decim.

Verification
REQ-033 audio_l=audio_r=0x80 for 64 strobes, without macro -> out_l=out_r=0, out_valid 3 clocks after the 64th strobe.
REQ-034 audio_l=0xFF, audio_r=0x00 for 64 strobes, without macro -> out_l=32512, out_r=-32768.
REQ-035 With AUDIO_DCBLOCK_EN, audio_l=0xFF constant -> out_l=32512 then 32385 on successive blocks, decaying towards 0.
REQ-036 Reset asserted after 40 strobes, then 64 strobes of 0xFF -> single out_valid; out_l=32512; no partial-block contribution.
REQ-037 Force start on two clocks 1 cycle apart -> one out_valid, overrun=1, held until reset.
REQ-038 ce_sample coincident with OUT state -> sample counted; next block sum exact (64 x 0xFF -> 32512).
